// File: rtl/free_list_mgr.sv
// Physical-register free list for the rename stage: a free bitmap with a
// lowest-index allocator, two release ports, flush, a free count and a sticky error flag.
module free_list_mgr #(
  parameter int SIZE      = 64,
  parameter int IDX_W     = $clog2(SIZE),
  parameter int INIT_USED = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             alloc_valid,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             alloc_take,
  input  logic             rel_valid0,
  input  logic [IDX_W-1:0] rel_idx0,
  input  logic             rel_valid1,
  input  logic [IDX_W-1:0] rel_idx1,
  input  logic             flush,
  output logic [IDX_W:0]   free_cnt,
  output logic             err
);

  localparam logic [IDX_W:0] INIT_FREE = (IDX_W+1)'(SIZE - INIT_USED);

  logic [SIZE-1:0] bitmap_reg, bitmap_next;
  logic [SIZE-1:0] init_map, hit0_vec, hit1_vec, take_vec;
  logic [IDX_W:0]  free_cnt_reg, free_cnt_next;
  logic            err_reg, err_next;
  logic            take, new0, new1, dup0, dup1, oor0, oor1, same_idx;

  // Per-entry decode. An index >= SIZE never matches any entry, so such a
  // release drops out of the bitmap update on its own.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_bit
      assign init_map[gi] = (gi >= INIT_USED);
      assign hit0_vec[gi] = rel_valid0 && (rel_idx0 == IDX_W'(gi));
      assign hit1_vec[gi] = rel_valid1 && (rel_idx1 == IDX_W'(gi));
      assign take_vec[gi] = take && (alloc_idx == IDX_W'(gi));
      // A release only sets a bit that was 0, so a release aimed at the
      // entry being taken this cycle cannot resurrect it.
      assign bitmap_next[gi] = flush ? init_map[gi]
                             : (bitmap_reg[gi] & ~take_vec[gi])
                             | (~bitmap_reg[gi] & (hit0_vec[gi] | hit1_vec[gi]));
    end
  endgenerate

  // Lowest set bit wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    alloc_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (bitmap_reg[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign alloc_valid = (free_cnt_reg != '0);
  assign take        = alloc_take & alloc_valid;

  // Port 1 yields to port 0 on an equal index so the entry is counted once.
  assign new0     = |(~bitmap_reg & hit0_vec);
  assign new1     = |(~bitmap_reg & hit1_vec & ~hit0_vec);
  assign dup0     = |(bitmap_reg & hit0_vec);
  assign dup1     = |(bitmap_reg & hit1_vec);
  assign oor0     = rel_valid0 & ~(|hit0_vec);
  assign oor1     = rel_valid1 & ~(|hit1_vec);
  assign same_idx = rel_valid0 & rel_valid1 & (rel_idx0 == rel_idx1);

  always_comb begin
    if (flush) begin
      free_cnt_next = INIT_FREE;
    end else begin
      free_cnt_next = free_cnt_reg - (IDX_W+1)'(take)
                    + (IDX_W+1)'(new0) + (IDX_W+1)'(new1);
    end
  end

  // A flush discards the cycle's take and releases, including their error checks.
  assign err_next = err_reg | (~flush & ((alloc_take & ~alloc_valid)
                                         | dup0 | dup1 | oor0 | oor1 | same_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_reg   <= init_map;
      free_cnt_reg <= INIT_FREE;
      err_reg      <= 1'b0;
    end else begin
      bitmap_reg   <= bitmap_next;
      free_cnt_reg <= free_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign free_cnt = free_cnt_reg;
  assign err      = err_reg;

endmodule
